fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 35 +++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage:
//   XLEN              - datapath / PC width
//   NOP               - instruction driven on invalid fetch output slots
//   FQ_DEPTH_DEFAULT  - default fetch queue depth
//   ICACHE_IF_PACKET  - per-slot {inst, valid} returned by the icache
//   IF_ID_PACKET      - per-slot {inst, PC, NPC, valid} handed to decode
//   fq_entry_t        - what the fetch queue actually stores per entry
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam int unsigned FQ_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic            valid;
  } ICACHE_IF_PACKET;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic            valid;
  } IF_ID_PACKET;

  // NPC is always PC+4 (no prediction), so it is rebuilt on read
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular buffer of fetched instructions: 0-2 pushes and 0-2 pops per cycle,
// single-cycle flush, occupancy count and a two-entry read window at the head.
// Ports:
//   clock, reset   - clock and synchronous active-high reset
//   flush          - empty the queue; pushes and pops in that cycle are dropped
//   push_count     - number of entries written this cycle (0..2)
//   push_data      - entries to write; [0] is the older one
//   pop_count      - number of entries retired from the head (0..2)
//   head_data      - entries at head and head+1
//   count          - current occupancy
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               push_count,
  input  fq_entry_t [1:0]          push_data,
  input  logic [1:0]               pop_count,
  output fq_entry_t [1:0]          head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Storage has no reset; validity is carried entirely by count.
  // DEPTH is a power of two, so pointer arithmetic wraps by itself.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      if (push_count != 2'd0) mem[tail] <= push_data[0];
      if (push_count == 2'd2) mem[tail + PTR_ONE] <= push_data[1];
    end
  end

  // Push and pop are summed into one count update, so simultaneous
  // push/pop is legal at any occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_count);
      tail  <= tail + PTR_W'(push_count);
      count <= count + CNT_W'(push_count) - CNT_W'(pop_count);
    end
  end

  assign head_data[0] = mem[head];
  assign head_data[1] = mem[head + PTR_ONE];

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Owns the fetch PC, drives the icache lookup address, accepts up to two
// aligned instructions per cycle into the fetch queue and presents up to two
// in-order instructions per cycle to decode. Redirects flush and restart.
// Ports:
//   clock, reset         - clock and synchronous active-high reset
//   icache_if_packet_in  - {inst, valid} per icache slot; slot 2 unused
//   redirect_en/pc       - back-end redirect and its target (bits [1:0] dropped)
//   dispatch_pop         - instructions consumed by dispatch this cycle (0..2)
//   proc2Icache_addr     - current fetch PC
//   if_packet_out        - {inst, PC, NPC, valid}; slot 0 is the oldest
//   fq_count             - fetch queue occupancy
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  ICACHE_IF_PACKET [2:0]       icache_if_packet_in,
  input  logic                        redirect_en,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic [1:0]                  dispatch_pop,
  output logic [XLEN-1:0]             proc2Icache_addr,
  output IF_ID_PACKET [1:0]           if_packet_out,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
  // Highest occupancy that still leaves room for a full two-wide fetch
  localparam logic [CNT_W-1:0] FETCH_LIMIT = CNT_W'(FQ_DEPTH - 2);

  logic [XLEN-1:0] fetch_pc;
  logic [1:0]      push_count;
  logic [1:0]      pop_count;
  fq_entry_t [1:0] push_data;
  fq_entry_t [1:0] head_data;
  logic            unused_inputs;

  assign unused_inputs    = ^{icache_if_packet_in[2], redirect_pc[1:0]};
  assign proc2Icache_addr = fetch_pc;

  // Fetch acceptance. When fetch_pc[2] is set the icache has already steered
  // the upper word into slot 0, so slot 1 is ignored. A slot-0 miss pushes
  // nothing and the PC holds so the cache keeps working on the same line.
  always_comb begin
    push_count = 2'd0;
    if (!redirect_en && fq_count <= FETCH_LIMIT && icache_if_packet_in[0].valid) begin
      if (fetch_pc[2] || !icache_if_packet_in[1].valid) push_count = 2'd1;
      else                                              push_count = 2'd2;
    end
  end

  assign pop_count = redirect_en ? 2'd0 : dispatch_pop;

  assign push_data[0] = '{inst: icache_if_packet_in[0].inst, pc: fetch_pc};
  assign push_data[1] = '{inst: icache_if_packet_in[1].inst, pc: fetch_pc + XLEN'(4)};

  // Reset beats redirect, redirect beats normal sequential fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_en) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      fetch_pc <= fetch_pc + XLEN'({push_count, 2'b00});
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_en),
    .push_count (push_count),
    .push_data  (push_data),
    .pop_count  (pop_count),
    .head_data  (head_data),
    .count      (fq_count)
  );

  // Invalid slots carry a NOP so downstream never sees stale instructions
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if_packet_out[k].valid = (fq_count > CNT_W'(k));
      if_packet_out[k].PC    = head_data[k].pc;
      if_packet_out[k].NPC   = head_data[k].pc + XLEN'(4);
      if_packet_out[k].inst  = if_packet_out[k].valid ? head_data[k].inst : NOP;
    end
  end

  // Dispatch may never consume more than is presented
  pop_within_count: assert property (
    @(posedge clock) disable iff (reset) (CNT_W'(dispatch_pop) <= fq_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed self-checking bench for fetch_stage (FQ_DEPTH = 8, RESET_PC = 0).
// Each icache instruction word is derived from its PC so that inst, PC and
// ordering can all be checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic                  clock;
  logic                  reset;
  ICACHE_IF_PACKET [2:0] icache_if_packet_in;
  logic                  redirect_en;
  logic [XLEN-1:0]       redirect_pc;
  logic [1:0]            dispatch_pop;
  logic [XLEN-1:0]       proc2Icache_addr;
  IF_ID_PACKET [1:0]     if_packet_out;
  logic [3:0]            fq_count;

  int vectors     = 0;
  int miscompares = 0;

  fetch_stage #(
    .FQ_DEPTH (8),
    .RESET_PC (32'h0)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .icache_if_packet_in (icache_if_packet_in),
    .redirect_en         (redirect_en),
    .redirect_pc         (redirect_pc),
    .dispatch_pop        (dispatch_pop),
    .proc2Icache_addr    (proc2Icache_addr),
    .if_packet_out       (if_packet_out),
    .fq_count            (fq_count)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  // Single comparison point; outputs are sampled 1 time unit after the edge
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Checks one valid output slot: valid bit, PC, NPC and instruction word
  task automatic check_pkt(input string tag, input int k, input logic [31:0] pc);
    check_output({tag, "_valid"}, 32'(if_packet_out[k].valid), 32'd1);
    check_output({tag, "_pc"},    if_packet_out[k].PC,         pc);
    check_output({tag, "_npc"},   if_packet_out[k].NPC,        pc + 32'd4);
    check_output({tag, "_inst"},  if_packet_out[k].inst,       inst_of(pc));
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr,
                             input logic [31:0] count);
    check_output({tag, "_addr"},  proc2Icache_addr, addr);
    check_output({tag, "_count"}, 32'(fq_count),    count);
  endtask

  task automatic check_empty(input string tag);
    check_output({tag, "_v0"}, 32'(if_packet_out[0].valid), 32'd0);
    check_output({tag, "_v1"}, 32'(if_packet_out[1].valid), 32'd0);
  endtask

  // Drives one cycle of inputs (icache returns the words at pc and pc+4),
  // clocks them in and returns just after the edge
  task automatic apply_stimulus(input logic [31:0] pc, input logic v0, input logic v1,
                                input logic [1:0] pop, input logic redir,
                                input logic [31:0] rpc);
    icache_if_packet_in[0] = {inst_of(pc), v0};
    icache_if_packet_in[1] = {inst_of(pc + 32'd4), v1};
    icache_if_packet_in[2] = {32'hDEAD_BEEF, 1'b1};
    dispatch_pop = pop;
    redirect_en  = redir;
    redirect_pc  = rpc;
    @(posedge clock);
    #1;
  endtask

  // Linear directed sequence
  initial begin
    reset = 1'b1;
    icache_if_packet_in = '0;
    redirect_en  = 1'b0;
    redirect_pc  = '0;
    dispatch_pop = 2'd0;

    // Reset state
    apply_stimulus(32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    apply_stimulus(32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    check_state("rst", 32'h0, 32'd0);
    check_empty("rst");
    reset = 1'b0;

    // Two-wide sequential hits
    apply_stimulus(32'h0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    check_state("seq1", 32'h8, 32'd2);
    check_pkt("seq1_s0", 0, 32'h0);
    check_pkt("seq1_s1", 1, 32'h4);
    apply_stimulus(32'h8, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0);
    check_state("seq2", 32'h10, 32'd2);
    check_pkt("seq2_s0", 0, 32'h8);
    check_pkt("seq2_s1", 1, 32'hC);

    // Redirect to an odd word (low bits ignored), then a single-slot push
    apply_stimulus(32'h10, 1'b1, 1'b1, 2'd2, 1'b1, 32'h107);
    check_state("redir1", 32'h104, 32'd0);
    check_empty("redir1");
    apply_stimulus(32'h104, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    check_state("odd", 32'h108, 32'd1);
    check_pkt("odd_s0", 0, 32'h104);
    check_output("odd_v1", 32'(if_packet_out[1].valid), 32'd0);

    // Miss for three cycles holds the PC
    apply_stimulus(32'h108, 1'b1, 1'b1, 2'd0, 1'b1, 32'h20);
    check_state("redir2", 32'h20, 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(32'h20, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
      check_state("miss", 32'h20, 32'd0);
      check_output("miss_v0", 32'(if_packet_out[0].valid), 32'd0);
    end
    apply_stimulus(32'h20, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    check_state("hit", 32'h28, 32'd2);
    check_pkt("hit_s0", 0, 32'h20);
    check_pkt("hit_s1", 1, 32'h24);

    // Fill the queue without popping: 4, 6, then 7 via a slot1 miss
    apply_stimulus(32'h28, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    check_state("fill4", 32'h30, 32'd4);
    apply_stimulus(32'h30, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    check_state("fill6", 32'h38, 32'd6);
    apply_stimulus(32'h38, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0);
    check_state("fill7", 32'h3C, 32'd7);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(32'h3C, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
      check_state("full", 32'h3C, 32'd7);
    end
    check_pkt("full_s0", 0, 32'h20);

    // Drain two per cycle while fetch resumes; order is kept across wrap
    apply_stimulus(32'h3C, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0);
    check_state("drain1", 32'h3C, 32'd5);
    check_pkt("drain1_s0", 0, 32'h28);
    check_pkt("drain1_s1", 1, 32'h2C);
    apply_stimulus(32'h3C, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0);
    check_state("drain2", 32'h40, 32'd4);
    check_pkt("drain2_s0", 0, 32'h30);
    check_pkt("drain2_s1", 1, 32'h34);
    apply_stimulus(32'h40, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0);
    check_state("drain3", 32'h48, 32'd4);
    check_pkt("drain3_s0", 0, 32'h38);
    check_pkt("drain3_s1", 1, 32'h3C);
    apply_stimulus(32'h48, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0);
    check_state("drain4", 32'h50, 32'd4);
    check_pkt("drain4_s0", 0, 32'h40);
    check_pkt("drain4_s1", 1, 32'h44);

    // Redirect together with a hit and a pop at count 4
    apply_stimulus(32'h50, 1'b1, 1'b1, 2'd2, 1'b1, 32'h400);
    check_state("redir3", 32'h400, 32'd0);
    check_empty("redir3");
    apply_stimulus(32'h400, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    check_state("tgt", 32'h408, 32'd2);
    check_pkt("tgt_s0", 0, 32'h400);
    check_pkt("tgt_s1", 1, 32'h404);

    // Reset wins over a simultaneous redirect with the queue half full
    apply_stimulus(32'h408, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0);
    check_state("half", 32'h410, 32'd4);
    reset = 1'b1;
    apply_stimulus(32'h410, 1'b1, 1'b1, 2'd2, 1'b1, 32'h800);
    check_state("rst2", 32'h0, 32'd0);
    check_empty("rst2");
    reset = 1'b0;
    apply_stimulus(32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    check_state("idle", 32'h0, 32'd0);
    check_empty("idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
